// File: rtl/spi_seq_pkg.sv
// Sequencer state encoding plus the register map and event bits of the controlled SPI controller.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CFG_OFF = 4'd1,
        S_CFG_ON  = 4'd2,
        S_READY   = 4'd3,
        S_POLL_NF = 4'd4,
        S_WR_TX   = 4'd5,
        S_POLL_NE = 4'd6,
        S_RD_RX   = 4'd7,
        S_SET_LST = 4'd8,
        S_POLL_LT = 4'd9,
        S_CLR_LT  = 4'd10,
        S_FAIL    = 4'd11
    } seq_state_e;

    localparam logic [31:0] OFF_CFG = 32'h20;
    localparam logic [31:0] OFF_EVT = 32'h24;
    localparam logic [31:0] OFF_LST = 32'h2C;
    localparam logic [31:0] OFF_TX  = 32'h30;
    localparam logic [31:0] OFF_RX  = 32'h34;

    localparam int BIT_EN  = 24;
    localparam int BIT_NF  = 8;
    localparam int BIT_NE  = 9;
    localparam int BIT_LT  = 14;
    localparam int BIT_LST = 22;

    localparam logic [31:0] EN_MASK  = 32'h1 << BIT_EN;
    localparam logic [31:0] LT_MASK  = 32'h1 << BIT_LT;
    localparam logic [31:0] LST_MASK = 32'h1 << BIT_LST;

endpackage

// File: rtl/apb_master_port.sv
// Single APB transfer engine: one setup/access pair per request, completion strobe with read data and error.
module apb_master_port (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        slverr_o,
    output logic [31:0] rdata_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    logic [1:0]  phase_q, phase_d;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:   if (req_i) phase_d = PH_SETUP;
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: if (pready_i) phase_d = PH_IDLE;
            default:   phase_d = PH_IDLE;
        endcase
    end

    // Address/data are captured once per request so they stay stable through wait states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (phase_q == PH_IDLE && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= write_i ? wdata_i : '0;
                write_q <= write_i;
            end
        end
    end

    assign psel_o    = (phase_q != PH_IDLE);
    assign penable_o = (phase_q == PH_ACCESS);
    assign pwrite_o  = psel_o && write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = pwrite_o ? wdata_q : '0;
    assign done_o    = penable_o && pready_i;
    assign slverr_o  = done_o && pslverr_i;
    assign rdata_o   = prdata_i;

endmodule

// File: rtl/spi_apb_sequencer.sv
// Drives an SPI controller's register file over APB: configure, stream TX/RX words, close out transfers.
module spi_apb_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0,
    parameter int          POLL_MAX = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] cfg_mode,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_wdata,
    input  logic        req_last,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam int             CW        = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0]  POLL_LAST = CW'(POLL_MAX - 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mode_q, mode_d;
    logic          last_q, last_d;

    logic          acc_req, acc_write, acc_done, acc_err;
    logic [31:0]   acc_addr, acc_wdata, acc_rdata;
    logic          poll_hit, is_poll;
    seq_state_e    poll_to;

    assign is_poll = (state_q == S_POLL_NF) || (state_q == S_POLL_NE) || (state_q == S_POLL_LT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        last_d    = last_q;
        acc_req   = 1'b1;
        acc_write = 1'b0;
        acc_addr  = BASE + OFF_EVT;
        acc_wdata = '0;
        poll_hit  = 1'b0;
        poll_to   = S_READY;
        case (state_q)
            S_IDLE, S_READY: begin
                acc_req = 1'b0;
                if (start) begin
                    mode_d  = cfg_mode;
                    state_d = S_CFG_OFF;
                end else if (state_q == S_READY && req_valid) begin
                    state_d = S_POLL_NF;
                end
            end
            S_CFG_OFF: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_CFG;
                acc_wdata = mode_q & ~EN_MASK;
                if (acc_done) state_d = S_CFG_ON;
            end
            S_CFG_ON: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_CFG;
                acc_wdata = mode_q | EN_MASK;
                if (acc_done) state_d = S_READY;
            end
            S_POLL_NF: begin
                poll_hit = acc_rdata[BIT_NF];
                poll_to  = S_WR_TX;
            end
            S_WR_TX: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_TX;
                acc_wdata = req_wdata;
                if (acc_done) begin
                    last_d  = req_last;
                    state_d = S_POLL_NE;
                end
            end
            S_POLL_NE: begin
                poll_hit = acc_rdata[BIT_NE];
                poll_to  = S_RD_RX;
            end
            S_RD_RX: begin
                acc_addr = BASE + OFF_RX;
                if (acc_done) state_d = last_q ? S_SET_LST : S_READY;
            end
            S_SET_LST: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_LST;
                acc_wdata = LST_MASK;
                if (acc_done) state_d = S_POLL_LT;
            end
            S_POLL_LT: begin
                poll_hit = acc_rdata[BIT_LT];
                poll_to  = S_CLR_LT;
            end
            S_CLR_LT: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_EVT;
                acc_wdata = LT_MASK;
                if (acc_done) state_d = S_READY;
            end
            S_FAIL: begin
                acc_write = 1'b1;
                acc_addr  = BASE + OFF_CFG;
                acc_wdata = mode_q & ~EN_MASK;
                if (acc_done) state_d = S_IDLE;
            end
            default: begin
                acc_req = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (is_poll && acc_done) begin
            if (poll_hit)                 state_d = poll_to;
            else if (cnt_q == POLL_LAST)  state_d = S_FAIL;
            else                          cnt_d   = cnt_q + CW'(1);
        end
        // A slave error aborts everything except the shutdown write itself.
        if (acc_err && state_q != S_FAIL) state_d = S_FAIL;
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
        end
    end

    apb_master_port u_apb (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (acc_req),
        .write_i   (acc_write),
        .addr_i    (acc_addr),
        .wdata_i   (acc_wdata),
        .done_o    (acc_done),
        .slverr_o  (acc_err),
        .rdata_o   (acc_rdata),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    assign busy      = (state_q != S_IDLE) && (state_q != S_READY);
    assign req_ready = (state_q == S_WR_TX) && acc_done;
    assign rsp_valid = (state_q == S_RD_RX) && acc_done && !acc_err;
    assign rsp_rdata = rsp_valid ? acc_rdata : '0;
    assign done      = (state_q == S_CLR_LT) && acc_done && !acc_err;
    assign err       = (state_q == S_FAIL) && acc_done;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer with a loopback APB SPI-controller model and an RX scoreboard.
module tb_spi_apb_sequencer;
    import spi_seq_pkg::*;

    localparam logic [31:0] TB_BASE = 32'h1000_0000;
    localparam int          TB_POLL = 8;

    logic        clk = 1'b0;
    logic        rstn, start, req_valid, req_last;
    logic [31:0] cfg_mode, req_wdata;
    logic        req_ready, rsp_valid, busy, done, err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    logic nf_force0 = 1'b0, ne_force0 = 1'b0, slverr_tx = 1'b0;
    int   wait_cycles = 0;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    spi_apb_sequencer #(.BASE(TB_BASE), .POLL_MAX(TB_POLL)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_mode(cfg_mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_wdata(req_wdata), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .done(done), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Loopback SPI controller model: TX writes land in a small RX FIFO.
    logic [31:0] fifo [0:7];
    logic [2:0]  wp = '0, rp = '0;
    logic        lt_flag = 1'b0;
    logic [31:0] evt, apb_off;
    int wcnt = 0, n_acc = 0, n_rsp = 0, n_done = 0, n_err = 0, n_rdy = 0, n_evt_rd = 0, wr_n = 0;
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];

    always_comb begin
        evt = '0;
        evt[8]  = !nf_force0;
        evt[9]  = (wp != rp) && !ne_force0;
        evt[14] = lt_flag;
    end
    assign apb_off = paddr - TB_BASE;
    assign pready  = psel && penable && (wcnt >= wait_cycles);
    assign pslverr = pready && slverr_tx && pwrite && (apb_off == 32'h30);
    assign prdata  = (apb_off == 32'h24) ? evt : (apb_off == 32'h34) ? fifo[rp] : 32'h0;

    always @(posedge clk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if (done) n_done <= n_done + 1;
        if (err) n_err <= n_err + 1;
        if (req_ready) n_rdy <= n_rdy + 1;
        if (psel && penable && pready) begin
            n_acc <= n_acc + 1;
            if (pwrite) begin
                wr_addr[wr_n[7:0]] <= apb_off;
                wr_data[wr_n[7:0]] <= pwdata;
                wr_n <= wr_n + 1;
                if (apb_off == 32'h30 && !pslverr) begin
                    fifo[wp] <= pwdata;
                    wp <= wp + 3'd1;
                end
                if (apb_off == 32'h2C && pwdata[22]) lt_flag <= 1'b1;
                if (apb_off == 32'h24 && pwdata[14]) lt_flag <= 1'b0;
            end else begin
                if (apb_off == 32'h24) n_evt_rd <= n_evt_rd + 1;
                if (apb_off == 32'h34 && wp != rp) rp <= rp + 3'd1;
            end
        end
    end

    task automatic do_start(input logic [31:0] mode);
        @(negedge clk);
        cfg_mode = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && dut.state_q != S_READY; i++) @(negedge clk);
        checks++;
        if (dut.state_q !== S_READY) begin
            errors++;
            $display("FAIL start_ready: state %0d, want %0d", dut.state_q, S_READY);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h busy=%b, want all 0",
                     psel, penable, pwrite, paddr, pwdata, busy);
        end
        checks++;
        if (dut.state_q !== S_IDLE || dut.cnt_q !== '0) begin
            errors++;
            $display("FAIL reset_state: state %0d cnt %0d, want IDLE/0", dut.state_q, dut.cnt_q);
        end
        rstn = 1'b1;
    endtask

    task automatic test_config();
        int w0;
        w0 = wr_n;
        do_start(32'h0004_0000);
        @(negedge clk);
        checks++;
        if (wr_n - w0 != 2) begin
            errors++;
            $display("FAIL cfg_write_count: got %0d, want 2", wr_n - w0);
        end
        checks++;
        if (wr_addr[w0[7:0]] !== 32'h20 || wr_data[w0[7:0]] !== 32'h0004_0000) begin
            errors++;
            $display("FAIL cfg_off: got %h:%h, want 20:00040000", wr_addr[w0[7:0]], wr_data[w0[7:0]]);
        end
        checks++;
        if (wr_addr[w0[7:0] + 8'd1] !== 32'h20 || wr_data[w0[7:0] + 8'd1] !== 32'h0104_0000) begin
            errors++;
            $display("FAIL cfg_on: got %h:%h, want 20:01040000", wr_addr[w0[7:0] + 8'd1], wr_data[w0[7:0] + 8'd1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_stream();
        int d0, r0, w0, y0, e0, idx, n_lst, n_clr;
        logic adv;
        logic [31:0] want;
        d0 = n_done; r0 = n_rsp; w0 = wr_n; y0 = n_rdy; e0 = n_err;
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'h5A5A_0002);
        idx = 0; adv = 1'b0;
        req_wdata = 32'hA5A5_0001; req_last = 1'b0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && !(n_done != d0 && exp_q.size() == 0); cyc++) begin
            @(negedge clk);
            if (adv) begin
                adv = 1'b0;
                idx++;
                if (idx == 1) begin
                    req_wdata = 32'h5A5A_0002;
                    req_last  = 1'b1;
                end else begin
                    req_valid = 1'b0;
                    req_last  = 1'b0;
                end
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_rsp_extra: got %h, want no response", rsp_rdata);
                end else begin
                    want = exp_q.pop_front();
                    if (rsp_rdata !== want) begin
                        errors++;
                        $display("FAIL stream_rsp_data: got %h, want %h", rsp_rdata, want);
                    end
                end
            end
            if (req_ready) adv = 1'b1;
        end
        req_valid = 1'b0;
        n_lst = 0; n_clr = 0;
        for (int i = w0; i < wr_n; i++) begin
            if (wr_addr[i[7:0]] == 32'h2C) n_lst += (wr_data[i[7:0]] == 32'h0040_0000) ? 1 : 100;
            if (wr_addr[i[7:0]] == 32'h24) n_clr += (wr_data[i[7:0]] == 32'h0000_4000) ? 1 : 100;
        end
        checks++;
        if (n_rsp - r0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_rsp_count: got %0d pending %0d, want 2 pending 0", n_rsp - r0, exp_q.size());
        end
        checks++;
        if (n_lst != 1) begin
            errors++;
            $display("FAIL stream_set_lst: got score %0d, want exactly one 2C:00400000", n_lst);
        end
        checks++;
        if (n_clr != 1) begin
            errors++;
            $display("FAIL stream_clr_lt: got score %0d, want exactly one 24:00004000", n_clr);
        end
        checks++;
        if (n_done - d0 != 1 || n_err != e0) begin
            errors++;
            $display("FAIL stream_done: got done %0d err %0d, want 1 and 0", n_done - d0, n_err - e0);
        end
        checks++;
        if (n_rdy - y0 != 2) begin
            errors++;
            $display("FAIL stream_req_ready: got %0d pulses, want 2", n_rdy - y0);
        end
    endtask

    task automatic test_timeout();
        int e0, p0, w0, r0;
        e0 = n_err; p0 = n_evt_rd; w0 = wr_n; r0 = n_rsp;
        nf_force0 = 1'b1;
        req_wdata = 32'hDEAD_0003; req_last = 1'b0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 500 && n_err == e0; cyc++) @(negedge clk);
        req_valid = 1'b0;
        nf_force0 = 1'b0;
        @(negedge clk);
        checks++;
        if (n_err - e0 != 1) begin
            errors++;
            $display("FAIL timeout_err: got %0d pulses, want 1", n_err - e0);
        end
        checks++;
        if (n_evt_rd - p0 != TB_POLL) begin
            errors++;
            $display("FAIL timeout_polls: got %0d, want %0d", n_evt_rd - p0, TB_POLL);
        end
        checks++;
        if (wr_n - w0 != 1 || wr_addr[w0[7:0]] !== 32'h20 || wr_data[w0[7:0]] !== 32'h0004_0000) begin
            errors++;
            $display("FAIL timeout_shutdown: got %0d writes, %h:%h, want 1 write 20:00040000",
                     wr_n - w0, wr_addr[w0[7:0]], wr_data[w0[7:0]]);
        end
        checks++;
        if (dut.state_q !== S_IDLE || busy !== 1'b0 || n_rsp != r0) begin
            errors++;
            $display("FAIL timeout_idle: state %0d busy %b rsp %0d, want IDLE 0 0", dut.state_q, busy, n_rsp - r0);
        end
    endtask

    task automatic test_slverr();
        int e0, r0, w0;
        do_start(32'h0004_0000);
        e0 = n_err; r0 = n_rsp; w0 = wr_n;
        slverr_tx = 1'b1;
        req_wdata = 32'h1234_0004; req_last = 1'b1; req_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && n_err == e0; cyc++) @(negedge clk);
        req_valid = 1'b0;
        slverr_tx = 1'b0;
        @(negedge clk);
        checks++;
        if (n_err - e0 != 1 || n_rsp != r0) begin
            errors++;
            $display("FAIL slverr_result: got err %0d rsp %0d, want 1 and 0", n_err - e0, n_rsp - r0);
        end
        checks++;
        if (wr_n - w0 != 2 || wr_addr[w0[7:0]] !== 32'h30 || wr_data[wr_n[7:0] - 8'd1] !== 32'h0004_0000) begin
            errors++;
            $display("FAIL slverr_writes: got %0d writes first %h last data %h, want 30 then 00040000",
                     wr_n - w0, wr_addr[w0[7:0]], wr_data[wr_n[7:0] - 8'd1]);
        end
        checks++;
        if (dut.state_q !== S_IDLE) begin
            errors++;
            $display("FAIL slverr_idle: state %0d, want %0d", dut.state_q, S_IDLE);
        end
    endtask

    task automatic test_wait_states();
        int a0;
        logic [31:0] hold_addr;
        a0 = n_acc;
        wait_cycles = 5;
        @(negedge clk);
        cfg_mode = 32'h0004_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5 && !psel; i++) @(negedge clk);
        hold_addr = paddr;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== TB_BASE + 32'h20) begin
            errors++;
            $display("FAIL wait_setup: psel %b pen %b paddr %h, want 1 0 %h", psel, penable, paddr, TB_BASE + 32'h20);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || pready !== 1'b0 || paddr !== hold_addr) begin
                errors++;
                $display("FAIL wait_hold_%0d: psel %b pen %b rdy %b paddr %h, want 1 1 0 %h",
                         k, psel, penable, pready, paddr, hold_addr);
            end
        end
        @(negedge clk);
        wait_cycles = 0;
        checks++;
        if (pready !== 1'b1 || penable !== 1'b1 || paddr !== hold_addr) begin
            errors++;
            $display("FAIL wait_complete: rdy %b pen %b paddr %h, want 1 1 %h", pready, penable, paddr, hold_addr);
        end
        @(negedge clk);
        checks++;
        if (n_acc - a0 != 1) begin
            errors++;
            $display("FAIL wait_one_access: got %0d, want 1", n_acc - a0);
        end
        for (int i = 0; i < 50 && dut.state_q != S_READY; i++) @(negedge clk);
        checks++;
        if (n_acc - a0 != 2 || dut.state_q !== S_READY) begin
            errors++;
            $display("FAIL wait_finish: got %0d accesses state %0d, want 2 READY", n_acc - a0, dut.state_q);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        ne_force0 = 1'b1;
        req_wdata = 32'hCAFE_0005; req_last = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 100 && !(dut.state_q == S_POLL_NE && psel); i++) @(negedge clk);
        checks++;
        if (dut.state_q !== S_POLL_NE) begin
            errors++;
            $display("FAIL rstmid_reach: state %0d, want %0d", dut.state_q, S_POLL_NE);
        end
        rstn = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, busy, done, err} !== '0 ||
            dut.state_q !== S_IDLE || dut.cnt_q !== '0) begin
            errors++;
            $display("FAIL rstmid_async: psel %b pen %b paddr %h busy %b state %0d, want all 0 IDLE",
                     psel, penable, paddr, busy, dut.state_q);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL rstmid_next: psel %b pen %b paddr %h busy %b, want all 0", psel, penable, paddr, busy);
        end
        rstn = 1'b1;
        ne_force0 = 1'b0;
        w0 = wr_n;
        do_start(32'h0004_0000);
        @(negedge clk);
        checks++;
        if (wr_n - w0 != 2 || wr_data[w0[7:0]] !== 32'h0004_0000 || wr_data[w0[7:0] + 8'd1] !== 32'h0104_0000) begin
            errors++;
            $display("FAIL rstmid_restart: got %0d writes %h %h, want 2 00040000 01040000",
                     wr_n - w0, wr_data[w0[7:0]], wr_data[w0[7:0] + 8'd1]);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; cfg_mode = '0;
        req_valid = 1'b0; req_wdata = '0; req_last = 1'b0;
        test_reset();
        test_config();
        test_stream();
        test_timeout();
        test_slverr();
        test_wait_states();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
